// File: rtl/rename_regfile.sv
// rename_regfile: register file with per-register rename busy/tag tracking and commit bypass
module rename_regfile #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              clear,
    input  logic              issue_flag,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic [REG_W-1:0]  rs1_idx,
    input  logic [REG_W-1:0]  rs2_idx,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [TAG_W-1:0]  rs1_tag,
    output logic [TAG_W-1:0]  rs2_tag,
    output logic [DATA_W-1:0] rs1_val,
    output logic [DATA_W-1:0] rs2_val,
    input  logic              commit_flag,
    input  logic [REG_W-1:0]  commit_rd,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [DATA_W-1:0] commit_val,
    output logic [5:0]        busy_cnt
);
    localparam int N = 1 << REG_W;
    logic [N-1:0]             busy, busy_n;
    logic [N-1:0][TAG_W-1:0]  tag, tag_n;
    logic [N-1:0][DATA_W-1:0] val, val_n;
    logic [5:0]               cnt_n;
    logic                     hit1, hit2;
    // x0 is never written, so its busy and val stay zero without special casing
    assign hit1 = busy[rs1_idx] && commit_flag && commit_rd == rs1_idx && commit_tag == tag[rs1_idx];
    assign hit2 = busy[rs2_idx] && commit_flag && commit_rd == rs2_idx && commit_tag == tag[rs2_idx];
    assign rs1_busy = busy[rs1_idx] && !hit1;
    assign rs2_busy = busy[rs2_idx] && !hit2;
    assign rs1_tag = rs1_busy ? tag[rs1_idx] : '0;
    assign rs2_tag = rs2_busy ? tag[rs2_idx] : '0;
    assign rs1_val = hit1 ? commit_val : (busy[rs1_idx] ? '0 : val[rs1_idx]);
    assign rs2_val = hit2 ? commit_val : (busy[rs2_idx] ? '0 : val[rs2_idx]);
    always_comb begin
        busy_n = busy;
        tag_n = tag;
        val_n = val;
        if (ready && commit_flag && commit_rd != '0) begin
            val_n[commit_rd] = commit_val;
            if (busy[commit_rd] && tag[commit_rd] == commit_tag) busy_n[commit_rd] = 1'b0;
        end
        if (ready && issue_flag && issue_rd != '0) begin
            busy_n[issue_rd] = 1'b1;
            tag_n[issue_rd] = issue_tag;
        end
        if (clear) begin
            busy_n = '0;
            tag_n = '0;
        end
        cnt_n = '0;
        for (int i = 0; i < N; i++) cnt_n = cnt_n + 6'(busy_n[i]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
            tag <= '0;
            val <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_n;
            tag <= tag_n;
            val <= val_n;
            busy_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed self-checking bench for rename_regfile
module tb_rename_regfile;
    logic        clk = 0;
    logic        reset, ready, clear, issue_flag, commit_flag;
    logic [4:0]  issue_rd, rs1_idx, rs2_idx, commit_rd;
    logic [3:0]  issue_tag, commit_tag, rs1_tag, rs2_tag;
    logic [31:0] commit_val, rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy;
    logic [5:0]  busy_cnt;
    int          errors = 0, checks = 0;

    rename_regfile dut (
        .clk(clk), .reset(reset), .ready(ready), .clear(clear),
        .issue_flag(issue_flag), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .commit_flag(commit_flag), .commit_rd(commit_rd),
        .commit_tag(commit_tag), .commit_val(commit_val),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic q1(input string name, input logic b, input logic [3:0] t, input logic [31:0] v);
        check({name, ".busy"}, 64'(rs1_busy), 64'(b));
        check({name, ".tag"}, 64'(rs1_tag), 64'(t));
        check({name, ".val"}, 64'(rs1_val), 64'(v));
    endtask

    task automatic q2(input string name, input logic b, input logic [3:0] t, input logic [31:0] v);
        check({name, ".busy"}, 64'(rs2_busy), 64'(b));
        check({name, ".tag"}, 64'(rs2_tag), 64'(t));
        check({name, ".val"}, 64'(rs2_val), 64'(v));
    endtask

    task automatic busy_range();
        for (int i = 1; i <= 10; i++) begin
            issue_flag = 1; issue_rd = 5'(i); issue_tag = 4'(i);
            step();
        end
        issue_flag = 0;
    endtask

    initial begin
        reset = 1; ready = 1; clear = 0; issue_flag = 0; commit_flag = 0;
        issue_rd = 0; issue_tag = 0; commit_rd = 0; commit_tag = 0; commit_val = 0;
        rs1_idx = 5; rs2_idx = 0;
        step(); step();
        reset = 0;
        check("rst.cnt", 64'(busy_cnt), 0);
        q1("rst.x5", 0, 0, 0);
        q2("rst.x0", 0, 0, 0);

        issue_flag = 1; issue_rd = 5; issue_tag = 3;
        step();
        issue_flag = 0;
        check("iss5.cnt", 64'(busy_cnt), 1);
        q1("iss5.x5", 1, 3, 0);
        commit_flag = 1; commit_rd = 5; commit_tag = 3; commit_val = 32'hDEADBEEF;
        #1;
        q1("byp5.x5", 0, 0, 32'hDEADBEEF);
        step();
        commit_flag = 0;
        check("cmt5.cnt", 64'(busy_cnt), 0);
        q1("cmt5.x5", 0, 0, 32'hDEADBEEF);

        rs2_idx = 7;
        issue_flag = 1; issue_rd = 7; issue_tag = 1;
        step();
        issue_tag = 4;
        step();
        issue_flag = 0;
        check("iss7.cnt", 64'(busy_cnt), 1);
        commit_flag = 1; commit_rd = 7; commit_tag = 1; commit_val = 9;
        #1;
        q2("stale7.byp", 1, 4, 0);
        step();
        commit_flag = 0;
        q2("stale7.after", 1, 4, 0);
        check("stale7.cnt", 64'(busy_cnt), 1);

        rs1_idx = 2;
        issue_flag = 1; issue_rd = 2; issue_tag = 5;
        step();
        check("iss2.cnt", 64'(busy_cnt), 2);
        issue_tag = 6;
        commit_flag = 1; commit_rd = 2; commit_tag = 5; commit_val = 32'h11;
        #1;
        q1("same2.byp", 0, 0, 32'h11);
        step();
        issue_flag = 0; commit_flag = 0;
        q1("same2.after", 1, 6, 0);
        check("same2.cnt", 64'(busy_cnt), 2);

        rs1_idx = 0;
        issue_flag = 1; issue_rd = 0; issue_tag = 2;
        commit_flag = 1; commit_rd = 0; commit_tag = 2; commit_val = 32'hFF;
        step();
        issue_flag = 0; commit_flag = 0;
        q1("x0", 0, 0, 0);
        check("x0.cnt", 64'(busy_cnt), 2);

        ready = 0;
        issue_flag = 1; issue_rd = 4; issue_tag = 1;
        commit_flag = 1; commit_rd = 2; commit_tag = 6; commit_val = 32'h55;
        step();
        ready = 1; issue_flag = 0; commit_flag = 0;
        rs1_idx = 4; rs2_idx = 2;
        #1;
        q1("frz.x4", 0, 0, 0);
        q2("frz.x2", 1, 6, 0);
        check("frz.cnt", 64'(busy_cnt), 2);

        busy_range();
        check("b10.cnt", 64'(busy_cnt), 10);
        clear = 1;
        commit_flag = 1; commit_rd = 3; commit_tag = 3; commit_val = 32'h42;
        issue_flag = 1; issue_rd = 12; issue_tag = 5;
        step();
        clear = 0; commit_flag = 0; issue_flag = 0;
        rs1_idx = 3; rs2_idx = 7;
        #1;
        check("clr.cnt", 64'(busy_cnt), 0);
        q1("clr.x3", 0, 0, 32'h42);
        q2("clr.x7", 0, 0, 9);
        rs1_idx = 12; rs2_idx = 2;
        #1;
        q1("clr.x12", 0, 0, 0);
        q2("clr.x2", 0, 0, 32'h11);

        busy_range();
        check("b10b.cnt", 64'(busy_cnt), 10);
        reset = 1;
        issue_flag = 1; issue_rd = 11; issue_tag = 2;
        commit_flag = 1; commit_rd = 3; commit_tag = 3; commit_val = 32'h77;
        step();
        reset = 0; issue_flag = 0; commit_flag = 0;
        rs1_idx = 3; rs2_idx = 11;
        #1;
        check("rst2.cnt", 64'(busy_cnt), 0);
        q1("rst2.x3", 0, 0, 0);
        q2("rst2.x11", 0, 0, 0);
        rs1_idx = 7; rs2_idx = 5;
        #1;
        q1("rst2.x7", 0, 0, 0);
        q2("rst2.x5", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 The parameters SHALL be, one per line as name, default, meaning:
- REG_W, 5, architectural register index width (32 registers).
- DATA_W, 32, register value width.
- TAG_W, 4, reorder-buffer index width (16 entries).
REQ-002 The ports SHALL be, one per line as name, direction, width, meaning:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- ready  input  1  global advance enable; issue/commit updates only when high.
- clear  input  1  misprediction flush from reorder buffer.
- issue_flag  input  1  rename destination of instruction being issued.
- issue_rd  input  REG_W  destination register of issuing instruction.
- issue_tag  input  TAG_W  reorder-buffer slot allocated to issuing instruction.
- rs1_idx, rs2_idx  input  REG_W  source registers queried.
- rs1_busy, rs2_busy  output  1  source awaits an in-flight producer.
- rs1_tag, rs2_tag  output  TAG_W  producer slot when busy, else 0.
- rs1_val, rs2_val  output  DATA_W  register value when not busy, else 0.
- commit_flag  input  1  reorder-buffer commit (unlock) valid.
- commit_rd  input  REG_W  committed destination register.
- commit_tag  input  TAG_W  reorder-buffer slot being committed.
- commit_val  input  DATA_W  committed result.
- busy_cnt  output  6  registered count of busy registers, 0..31.

Function
REQ-003 State SHALL be, per register: val[DATA_W], busy[1], tag[TAG_W]; x0 SHALL hold val=0, busy=0 permanently.
REQ-004 Query outputs SHALL be combinational from current state plus same-cycle commit bypass; zero-latency.
REQ-005 Query for x0 SHALL return busy=0, tag=0, val=0.
REQ-006 Query for register r with busy[r]=1 and commit_flag=1, commit_rd=r, commit_tag=tag[r] SHALL return busy=0, val=commit_val (bypass).
REQ-007 Query otherwise SHALL return busy[r], tag[r] (0 if not busy), val[r] (0 if busy).
REQ-008 Queries SHALL NOT reflect same-cycle issue: an instruction whose rs equals its own rd sees the prior mapping.
REQ-009 Commit at posedge (ready=1, commit_flag=1, commit_rd!=0) SHALL write val[commit_rd]<=commit_val unconditionally.
REQ-010 Commit SHALL clear busy[commit_rd] only if busy=1 and tag[commit_rd]==commit_tag; a stale tag leaves busy/tag unchanged.
REQ-011 Issue at posedge (ready=1, issue_flag=1, issue_rd!=0) SHALL set busy[issue_rd]<=1, tag[issue_rd]<=issue_tag.
REQ-012 Issue and commit to the same register in one cycle: value written, issue wins for busy/tag (busy=1, tag=issue_tag).
REQ-013 issue_rd=0 or commit_rd=0 SHALL cause no state change.
REQ-014 clear=1 at posedge (any ready) SHALL set all busy<=0, tags<=0; same-cycle commit value SHALL still be written if ready=1; same-cycle issue SHALL be discarded.
REQ-015 ready=0 SHALL freeze val/busy/tag except clear; query outputs remain valid.
REQ-016 busy_cnt SHALL equal the number of busy registers after each posedge update (population count of next-state busy), one-cycle registered latency relative to issue/commit.

Reset
REQ-017 reset=1 at posedge SHALL set all val=0, busy=0, tag=0, busy_cnt=0; reset SHALL override clear, issue, commit.
REQ-018 After reset every query SHALL return busy=0, tag=0, val=0.

Verification
REQ-019 Issue rd=5 tag=3; next cycle query rs1=5 -> busy=1, tag=3; commit rd=5 tag=3 val=0xDEADBEEF same cycle as query -> rs1_busy=0, rs1_val=0xDEADBEEF; after edge busy_cnt=0.
REQ-020 Issue rd=7 tag=1, then rd=7 tag=4; commit rd=7 tag=1 val=9 -> val[7]=9, busy=1, tag=4 retained.
REQ-021 Same cycle issue rd=2 tag=6 and commit rd=2 (matching prior tag 5) val=0x11 -> busy=1, tag=6, val=0x11.
REQ-022 Issue rd=0 tag=2, commit rd=0 val=0xFF -> query x0 returns 0/not busy, busy_cnt unchanged.
REQ-023 Busy x1..x10, then clear with commit rd=3 val=0x42 -> all busy=0, busy_cnt=0, val[3]=0x42.
REQ-024 ready=0 with issue rd=4 tag=1 -> no state change; reset mid-sequence with 10 busy -> all state zero next cycle.
